// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg: shared state encoding, synchroniser depth limits and counter saturation helper
package pulse_sync_pkg;
  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  function automatic int unsigned cnt_sat(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/sync_bit_chain.sv
// sync_bit_chain: multi-flop synchroniser for one asynchronous bit
module sync_bit_chain #(
  parameter int STAGES = 2
) (
  input  logic dst_clk,
  input  logic dst_reset,
  input  logic d,
  output logic q
);
  (* syn_preserve = 1 *) logic [STAGES-1:0] sr;
  always_ff @(posedge dst_clk)
    sr <= !dst_reset ? '0 : {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/pulse_sync_rx.sv
// pulse_sync_rx: turns synchronised toggle edges into queued valid/ready events with toggle acknowledge
module pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             dst_clk,
  input  logic             dst_reset,
  input  logic             toggle_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             ack_toggle_out,
  output logic [CNT_W-1:0] pend_count,
  output logic             overflow,
  input  logic             overflow_clr
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));
  state_t           state, state_n;
  logic [2:0]       prime_cnt, prime_cnt_n;
  logic             sync_out, toggle_ref, toggle_ref_n;
  logic             prime_done, evt, consume, sat;
  logic [CNT_W-1:0] pend_n;
  logic             ack_n, overflow_n;
  sync_bit_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .dst_clk   (dst_clk),
    .dst_reset (dst_reset),
    .d         (toggle_in),
    .q         (sync_out)
  );
  assign evt_valid = pend_count != '0;
  assign consume   = evt_valid & evt_ready;
  assign sat       = pend_count == CNT_MAX;
  always_ff @(posedge dst_clk) begin
    if (!dst_reset) begin
      state          <= ST_PRIME;
      prime_cnt      <= '0;
      toggle_ref     <= 1'b0;
      pend_count     <= '0;
      ack_toggle_out <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_n;
      prime_cnt      <= prime_cnt_n;
      toggle_ref     <= toggle_ref_n;
      pend_count     <= pend_n;
      ack_toggle_out <= ack_n;
      overflow       <= overflow_n;
    end
  end
  // the last prime cycle adopts the synchronised level so a high toggle_in at release is not an event
  always_comb begin
    prime_done   = state == ST_PRIME && prime_cnt == 3'(SYNC_STAGES);
    evt          = state == ST_RUN && (sync_out ^ toggle_ref);
    state_n      = prime_done ? ST_RUN : state;
    prime_cnt_n  = state == ST_PRIME ? prime_cnt + 3'd1 : prime_cnt;
    toggle_ref_n = (prime_done || evt) ? sync_out : toggle_ref;
    pend_n       = (evt && !consume && !sat) ? pend_count + 1'b1 :
                   (!evt && consume)         ? pend_count - 1'b1 : pend_count;
    ack_n        = ack_toggle_out ^ consume;
    overflow_n   = (evt && !consume && sat) || (overflow && !overflow_clr);
  end
endmodule

// File: tb/tb_pulse_sync_rx.sv
// tb_pulse_sync_rx: directed stimulus with an ack scoreboard popped by a consume monitor
module tb_pulse_sync_rx;
  logic       dst_clk = 1'b0;
  logic       dst_reset = 1'b0;
  logic       toggle_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       evt_valid, ack_toggle_out, overflow;
  logic [3:0] pend_count;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       exp_q[$];
  logic       exp_ack = 1'b0;
  logic       mon_e;

  pulse_sync_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .dst_clk        (dst_clk),
    .dst_reset      (dst_reset),
    .toggle_in      (toggle_in),
    .evt_ready      (evt_ready),
    .evt_valid      (evt_valid),
    .ack_toggle_out (ack_toggle_out),
    .pend_count     (pend_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  always #5 dst_clk = ~dst_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge dst_clk);
    #1;
  endtask

  // queued=1 means the event is expected to be counted and later consumed
  task automatic tog(input bit queued);
    toggle_in = ~toggle_in;
    if (queued) begin
      exp_ack = ~exp_ack;
      exp_q.push_back(exp_ack);
    end
  endtask

  always @(negedge dst_clk) begin
    if (dst_reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL consume_unexpected: got ack %0b required no consume", ack_toggle_out);
      end else begin
        mon_e = exp_q.pop_front();
        @(posedge dst_clk);
        #1;
        check("consume_ack", 32'(ack_toggle_out), 32'(mon_e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    toggle_in = 1'b1;
    step(3);
    check("rst_pend", 32'(pend_count), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ack", 32'(ack_toggle_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    dst_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("prime_valid", 32'(evt_valid), 0);
      check("prime_pend", 32'(pend_count), 0);
    end
    tog(1'b1);
    step(1);
    check("lat_e0", 32'(pend_count), 0);
    step(1);
    check("lat_e1", 32'(pend_count), 0);
    step(1);
    check("lat_e2_pend", 32'(pend_count), 1);
    check("lat_e2_valid", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("lat_cons_pend", 32'(pend_count), 0);
    check("lat_cons_ack", 32'(ack_toggle_out), 1);
    for (int i = 0; i < 5; i++) begin
      tog(1'b1);
      step(4);
    end
    check("queue_pend", 32'(pend_count), 5);
    evt_ready = 1'b1;
    step(8);
    evt_ready = 1'b0;
    check("queue_drain", 32'(pend_count), 0);
    check("queue_ack", 32'(ack_toggle_out), 32'(exp_ack));
    for (int i = 0; i < 3; i++) begin
      tog(1'b1);
      step(4);
    end
    check("simul_pre", 32'(pend_count), 3);
    tog(1'b1);
    step(2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("simul_pend", 32'(pend_count), 3);
    check("simul_ack", 32'(ack_toggle_out), 1);
    evt_ready = 1'b1;
    step(5);
    evt_ready = 1'b0;
    check("simul_drain", 32'(pend_count), 0);
    for (int i = 0; i < 16; i++) begin
      tog(i < 15);
      step(4);
    end
    check("sat_pend", 32'(pend_count), 15);
    check("sat_ovf", 32'(overflow), 1);
    tog(1'b0);
    step(2);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("sat_clr_race", 32'(overflow), 1);
    check("sat_clr_race_pend", 32'(pend_count), 15);
    step(2);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("sat_clr", 32'(overflow), 0);
    tog(1'b1);
    step(2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("sat_cons_pend", 32'(pend_count), 15);
    check("sat_cons_ovf", 32'(overflow), 0);
    evt_ready = 1'b1;
    step(9);
    evt_ready = 1'b0;
    check("mid_pend", 32'(pend_count), 6);
    step(1);
    dst_reset = 1'b0;
    step(1);
    dst_reset = 1'b1;
    exp_q.delete();
    exp_ack = 1'b0;
    check("mid_rst_pend", 32'(pend_count), 0);
    check("mid_rst_ack", 32'(ack_toggle_out), 0);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("mid_prime_pend", 32'(pend_count), 0);
    end
    tog(1'b1);
    step(4);
    check("post_pend", 32'(pend_count), 1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("post_ack", 32'(ack_toggle_out), 1);
    step(3);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
